pipe_reg_ctrl: RTL

- Consumer of the per-lane stall/nop masks produced by hazard detection for the dual-issue pipeline.
- Owns the PC register, the two-lane IF_ID registers and the two-lane ID_EX registers, and applies hold, bubble-insert and load to each.
- Also applies branch flush and keeps saturating stall/bubble performance counters.
- Sits between instruction fetch/decode and the execute stage.

---
 rtl/pipe_reg_ctrl_pkg.sv | 16 +
 rtl/pipe_lane_reg.sv | 48 ++++
 rtl/pipe_reg_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_reg_ctrl_pkg.sv
// Shared pipeline-register constants: mask bit layout, NOP opcode and NOP encodings.
package pipe_reg_ctrl_pkg;

  localparam int PIPE_REG_PC    = 0;
  localparam int PIPE_REG_IF_ID = 1;
  localparam int PIPE_REG_ID_EX = 2;
  localparam int NUM_PIPE_MASKS = 3;

  typedef logic [NUM_PIPE_MASKS-1:0] pipe_mask_t;

  // A NOP carries OP_CODE_NOP in the top OP_CODE_BITS of the word, zeros elsewhere.
  // The same layout is used for instruction words and for decoded payloads.
  localparam int                     OP_CODE_BITS = 6;
  localparam logic [OP_CODE_BITS-1:0] OP_CODE_NOP = 6'h3F;

endpackage

// File: rtl/pipe_lane_reg.sv
// One pipeline-register lane with a valid bit; per-edge priority is flush > nop > stall > load.
// flush and nop both turn the lane into NOP_VAL with valid cleared.
module pipe_lane_reg
  import pipe_reg_ctrl_pkg::*;
#(
  parameter int           W       = 32,
  parameter logic [W-1:0] NOP_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         nop_i,
  input  logic         stall_i,
  input  logic [W-1:0] dat_i,
  input  logic         vld_i,
  output logic [W-1:0] dat_o,
  output logic         vld_o
);

  logic [W-1:0] dat_q, dat_d;
  logic         vld_q, vld_d;

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    if (flush_i || nop_i) begin
      dat_d = NOP_VAL;
      vld_d = 1'b0;
    end else if (!stall_i) begin
      dat_d = dat_i;
      vld_d = vld_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= NOP_VAL;
      vld_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
    end
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pipe_reg_ctrl.sv
// Dual-issue PC / IF_ID / ID_EX register control driven by per-lane stall and nop masks,
// with branch flush and saturating stall/bubble counters. All effects land on the next edge.
module pipe_reg_ctrl
  import pipe_reg_ctrl_pkg::*;
#(
  parameter int                    INSTR_WIDTH   = 32,
  parameter int                    PAYLOAD_WIDTH = 64,
  parameter int                    ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET      = '0,
  parameter int                    CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_PIPE_MASKS-1:0] stall0,
  input  logic [NUM_PIPE_MASKS-1:0] stall1,
  input  logic [NUM_PIPE_MASKS-1:0] nop0,
  input  logic [NUM_PIPE_MASKS-1:0] nop1,
  input  logic                     flush,
  input  logic [ADDR_WIDTH-1:0]    branch_target,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_instr0,
  input  logic [INSTR_WIDTH-1:0]   imem_instr1,
  input  logic [PAYLOAD_WIDTH-1:0] dec_payload0,
  input  logic [PAYLOAD_WIDTH-1:0] dec_payload1,
  output logic [ADDR_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0]   if_id_instr0,
  output logic [INSTR_WIDTH-1:0]   if_id_instr1,
  output logic [ADDR_WIDTH-1:0]    if_id_pc0,
  output logic [ADDR_WIDTH-1:0]    if_id_pc1,
  output logic                     if_id_valid0,
  output logic                     if_id_valid1,
  output logic [PAYLOAD_WIDTH-1:0] id_ex_payload0,
  output logic [PAYLOAD_WIDTH-1:0] id_ex_payload1,
  output logic                     id_ex_valid0,
  output logic                     id_ex_valid1,
  output logic [CNT_WIDTH-1:0]     stall_cnt,
  output logic [CNT_WIDTH-1:0]     bubble_cnt
);

  localparam int IF_W = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR =
    {OP_CODE_NOP, {(INSTR_WIDTH-OP_CODE_BITS){1'b0}}};
  localparam logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD =
    {OP_CODE_NOP, {(PAYLOAD_WIDTH-OP_CODE_BITS){1'b0}}};
  localparam logic [IF_W-1:0] NOP_IF_ID = {NOP_INSTR, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic                  pc_hold;
  logic [1:0]            bubble_add;
  logic [CNT_WIDTH:0]    bubble_sum;
  logic [IF_W-1:0]       if_id_dat0, if_id_dat1;

  assign pc_hold = stall0[PIPE_REG_PC] | stall1[PIPE_REG_PC];

  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(2);
    if (flush)        pc_d = branch_target;
    else if (pc_hold) pc_d = pc_q;
  end

  // Counters only see cycles where the flush did not override the masks.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    bubble_add = 2'd0;
    if (!flush)
      bubble_add = {1'b0, nop0[PIPE_REG_ID_EX]} + {1'b0, nop1[PIPE_REG_ID_EX]};
    bubble_sum   = {1'b0, bubble_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, bubble_add};
    bubble_cnt_d = bubble_sum[CNT_WIDTH] ? '1 : bubble_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= PC_RESET;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  pipe_lane_reg #(.W(IF_W), .NOP_VAL(NOP_IF_ID)) u_if_id0 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .nop_i(nop0[PIPE_REG_IF_ID]), .stall_i(stall0[PIPE_REG_IF_ID]),
    .dat_i({imem_instr0, pc_q}), .vld_i(1'b1),
    .dat_o(if_id_dat0), .vld_o(if_id_valid0)
  );

  pipe_lane_reg #(.W(IF_W), .NOP_VAL(NOP_IF_ID)) u_if_id1 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .nop_i(nop1[PIPE_REG_IF_ID]), .stall_i(stall1[PIPE_REG_IF_ID]),
    .dat_i({imem_instr1, pc_q + ADDR_WIDTH'(1)}), .vld_i(1'b1),
    .dat_o(if_id_dat1), .vld_o(if_id_valid1)
  );

  // ID_EX valid follows the IF_ID valid of the same lane.
  pipe_lane_reg #(.W(PAYLOAD_WIDTH), .NOP_VAL(NOP_PAYLOAD)) u_id_ex0 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .nop_i(nop0[PIPE_REG_ID_EX]), .stall_i(stall0[PIPE_REG_ID_EX]),
    .dat_i(dec_payload0), .vld_i(if_id_valid0),
    .dat_o(id_ex_payload0), .vld_o(id_ex_valid0)
  );

  pipe_lane_reg #(.W(PAYLOAD_WIDTH), .NOP_VAL(NOP_PAYLOAD)) u_id_ex1 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .nop_i(nop1[PIPE_REG_ID_EX]), .stall_i(stall1[PIPE_REG_ID_EX]),
    .dat_i(dec_payload1), .vld_i(if_id_valid1),
    .dat_o(id_ex_payload1), .vld_o(id_ex_valid1)
  );

  assign if_id_instr0 = if_id_dat0[IF_W-1:ADDR_WIDTH];
  assign if_id_pc0    = if_id_dat0[ADDR_WIDTH-1:0];
  assign if_id_instr1 = if_id_dat1[IF_W-1:ADDR_WIDTH];
  assign if_id_pc1    = if_id_dat1[ADDR_WIDTH-1:0];

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
